// File: rtl/pe_array_pkg.sv
// Shared types and instruction field layout for the PE array scheduler.
package pe_array_pkg;

   typedef enum logic [1:0] {
      ADD     = 2'b00,
      SUB     = 2'b01,
      AND     = 2'b10,
      XOR_MUL = 2'b11
   } alu_op_t;

   typedef enum logic {
      FILL = 1'b0,
      DONE = 1'b1
   } sched_state_t;

   localparam int ALU_OP_LSB   = 0;
   localparam int ALU_OP_W     = 2;
   localparam int USE_IMM1_BIT = 2;
   localparam int USE_IMM0_BIT = 3;
   localparam int OP1_LSB      = 4;

   function automatic int op0_lsb(input int data_w);
      return data_w + 4;
   endfunction

   function automatic int instr_width(input int data_w);
      return 2 * data_w + 4;
   endfunction

endpackage

// File: rtl/pe_alu.sv
// Combinational PE arithmetic unit; results wrap modulo 2^DATA_W.
// Build option PE_ARRAY_MUL_EN turns alu_op XOR_MUL into a multiply.
module pe_alu
   import pe_array_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  alu_op_t           alu_op,
   input  logic [DATA_W-1:0] op0,
   input  logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (alu_op)
         ADD:     y = op0 + op1;
         SUB:     y = op0 - op1;
         AND:     y = op0 & op1;
`ifdef PE_ARRAY_MUL_EN
         XOR_MUL: y = op0 * op1;
`else
         XOR_MUL: y = op0 ^ op1;
`endif
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/pe_array_sched.sv
// PE array scheduler: places each instruction in the next PE slot, checks operand
// dataflow, and hands the final result out over a valid/ready port.
module pe_array_sched
   import pe_array_pkg::*;
#(
   parameter int NUM_PE = 4,
   parameter int DATA_W = 4,
   localparam int SEL_W   = $clog2(NUM_PE),
   localparam int INSTR_W = 2 * DATA_W + 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INSTR_W-1:0]       instr,
   input  logic                     instr_valid,
   input  logic                     instr_last,
   output logic                     instr_ready,
   output logic                     instr_fault,
   output logic [SEL_W-1:0]         slot,
   output logic [NUM_PE*DATA_W-1:0] pe_out,
   output logic [DATA_W-1:0]        result,
   output logic                     result_valid,
   input  logic                     result_ready
);

   localparam int OP0_LSB = op0_lsb(DATA_W);

   sched_state_t state, next_state;

   logic [NUM_PE-1:0][DATA_W-1:0] pe_reg;
   logic [DATA_W-1:0] op0_field, op1_field, op0, op1, alu_y;
   logic              use_imm0, use_imm1, op0_ok, op1_ok, legal, accept, finish;
   alu_op_t           alu_op;

   assign op0_field = instr[OP0_LSB +: DATA_W];
   assign op1_field = instr[OP1_LSB +: DATA_W];
   assign use_imm0  = instr[USE_IMM0_BIT];
   assign use_imm1  = instr[USE_IMM1_BIT];
   assign alu_op    = alu_op_t'(instr[ALU_OP_LSB +: ALU_OP_W]);

   // Comparing the whole field against slot also rejects nonzero upper bits.
   assign op0_ok = use_imm0 || (op0_field < DATA_W'(slot));
   assign op1_ok = use_imm1 || (op1_field < DATA_W'(slot));
   assign legal  = op0_ok && op1_ok;

   assign op0 = use_imm0 ? op0_field : pe_reg[op0_field[SEL_W-1:0]];
   assign op1 = use_imm1 ? op1_field : pe_reg[op1_field[SEL_W-1:0]];

   assign accept = instr_valid && instr_ready;
   assign finish = instr_last || (slot == SEL_W'(NUM_PE - 1));
   assign pe_out = pe_reg;

   pe_alu #(.DATA_W(DATA_W)) u_alu (
      .alu_op (alu_op),
      .op0    (op0),
      .op1    (op1),
      .y      (alu_y)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FILL;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      instr_ready = 1'b0;
      case (state)
         FILL: begin
            instr_ready = 1'b1;
            if (accept && legal && finish) next_state = DONE;
         end
         DONE: begin
            if (result_ready) next_state = FILL;
         end
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot         <= '0;
         pe_reg       <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         instr_fault  <= 1'b0;
      end else begin
         instr_fault <= accept && !legal;
         if (state == DONE) begin
            if (result_ready) begin
               result_valid <= 1'b0;
               pe_reg       <= '0;
            end
         end else if (accept) begin
            if (!legal) begin
               pe_reg <= '0;
               slot   <= '0;
            end else begin
               pe_reg[slot] <= alu_y;
               if (finish) begin
                  result       <= alu_y;
                  result_valid <= 1'b1;
                  slot         <= '0;
               end else begin
                  slot <= slot + 1'b1;
               end
            end
         end
      end
   end

endmodule
